// File: rtl/eth_mdio_pkg.sv
// Shared constants and types for the Clause-22 MDIO master.
// Frame field offsets are counted from the first bit after the preamble.
package eth_mdio_pkg;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int F_ST    = 0;
  localparam int F_OP    = 2;
  localparam int F_PHYAD = 4;
  localparam int F_REGAD = 9;
  localparam int F_TA    = 14;
  localparam int F_DATA  = 16;
  localparam int F_LEN   = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} mdio_state_t;

endpackage

// File: rtl/eth_mdio_clkgen.sv
// MDC prescaler: CLK_DIV cycles low, then CLK_DIV cycles high, while enabled.
// The strobes flag the last cycle of each half-period.
module eth_mdio_clkgen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] cnt_q, cnt_d;
  logic       mdc_q, mdc_d;
  logic       wrap;

  assign wrap     = en && (cnt_q == 8'(CLK_DIV - 1));
  assign rise_stb = wrap && !mdc_q;
  assign fall_stb = wrap && mdc_q;
  assign mdc      = mdc_q;

  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      mdc_d = !mdc_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO management master: serialises one read/write frame per
// command and returns read data plus a no-PHY flag from the TA bit.
module eth_mdio_master #(
  parameter int CLK_DIV       = 50,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        msoc_clk,
  input  logic        rst_int_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  input  logic        phy_mdio_i,
  output logic        phy_mdio_o,
  output logic        phy_mdio_oe,
  output logic        phy_mdc
);
  import eth_mdio_pkg::*;

  localparam int N     = PREAMBLE_BITS + F_LEN;
  localparam int TA_IN = PREAMBLE_BITS + F_TA + 1;
  localparam int DATA0 = PREAMBLE_BITS + F_DATA;

  mdio_state_t state_q, state_d;
  logic [6:0]  bit_q, bit_d, nxt_bit;
  logic [31:0] frame_q, frame_d;
  logic        rd_q, rd_d;
  logic        mdio_o_q, mdio_o_d, mdio_oe_q, mdio_oe_d;
  logic [15:0] rsh_q, rsh_d, rdata_q, rdata_d;
  logic        esh_q, esh_d, err_q, err_d;
  logic        accept, drv_o, drv_oe, rise_stb, fall_stb;
  logic [4:0]  fidx;

  eth_mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (msoc_clk),
    .rst_n    (rst_int_n),
    .en       (state_q == SHIFT),
    .mdc      (phy_mdc),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    rd_d      = rd_q;
    mdio_o_d  = mdio_o_q;
    mdio_oe_d = mdio_oe_q;
    rsh_d     = rsh_q;
    esh_d     = esh_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    accept = (state_q == IDLE) && cmd_valid;
    if (accept) begin
      // Read frames leave TA/DATA undriven, so their payload is don't-care.
      frame_d = {ST_CODE, cmd_read ? OP_READ : OP_WRITE, cmd_phy_addr, cmd_reg_addr,
                 cmd_read ? 2'b11 : TA_WRITE, cmd_read ? 16'hFFFF : cmd_wdata};
      rd_d    = cmd_read;
    end

    // Pad values for the bit that starts with the upcoming low phase.
    nxt_bit = accept ? 7'd0 : bit_q + 7'd1;
    fidx    = 5'(int'(nxt_bit) - PREAMBLE_BITS);
    drv_o   = (int'(nxt_bit) < PREAMBLE_BITS) ? 1'b1 : frame_d[5'd31 - fidx];
    drv_oe  = !rd_d || (int'(nxt_bit) < PREAMBLE_BITS + F_TA);

    case (state_q)
      IDLE: if (accept) begin
        state_d   = SHIFT;
        bit_d     = '0;
        mdio_o_d  = drv_o;
        mdio_oe_d = drv_oe;
      end
      SHIFT: begin
        if (rise_stb) begin
          if (int'(bit_q) == TA_IN) esh_d = phy_mdio_i;
          if (int'(bit_q) >= DATA0) rsh_d = {rsh_q[14:0], phy_mdio_i};
        end
        if (fall_stb) begin
          if (int'(bit_q) == N - 1) begin
            state_d   = DONE;
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
            rdata_d   = rd_q ? rsh_q : 16'h0000;
            err_d     = rd_q && esh_q;
          end else begin
            bit_d     = nxt_bit;
            mdio_o_d  = drv_o;
            mdio_oe_d = drv_oe;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge msoc_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      frame_q   <= '0;
      rd_q      <= 1'b0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
      rsh_q     <= '0;
      esh_q     <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      rd_q      <= rd_d;
      mdio_o_q  <= mdio_o_d;
      mdio_oe_q <= mdio_oe_d;
      rsh_q     <= rsh_d;
      esh_q     <= esh_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign phy_mdio_o  = mdio_o_q;
  assign phy_mdio_oe = mdio_oe_q;

endmodule

// File: tb/tb_eth_mdio_master.sv
// Randomised bench for eth_mdio_master: per-cycle frame/pad model derived from
// the Clause-22 bit layout, with a PHY responder driving phy_mdio_i.
module tb_eth_mdio_master;

  localparam int CDIV = 2;

  logic        msoc_clk = 1'b0;
  logic        rst_int_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_read = 1'b0;
  logic [4:0]  cmd_phy_addr = '0;
  logic [4:0]  cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        phy_mdio_i = 1'b1;
  logic        sel = 1'b0;

  logic        rdy_a, rv_a, err_a, busy_a, o_a, oe_a, mdc_a;
  logic        rdy_b, rv_b, err_b, busy_b, o_b, oe_b, mdc_b;
  logic [15:0] rd_a, rd_b;

  logic        o_ready, o_rv, o_err, o_busy, o_o, o_oe, o_mdc;
  logic [15:0] o_rdata;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] last_rd = '0;
  logic        last_err = 1'b0;

  always #5 msoc_clk = ~msoc_clk;

  eth_mdio_master #(.CLK_DIV(CDIV), .PREAMBLE_BITS(32)) u_dut (
    .msoc_clk(msoc_clk), .rst_int_n(rst_int_n),
    .cmd_valid(cmd_valid & ~sel), .cmd_ready(rdy_a), .cmd_read(cmd_read),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a), .busy(busy_a),
    .phy_mdio_i(phy_mdio_i), .phy_mdio_o(o_a), .phy_mdio_oe(oe_a), .phy_mdc(mdc_a)
  );

  eth_mdio_master #(.CLK_DIV(CDIV), .PREAMBLE_BITS(0)) u_dut0 (
    .msoc_clk(msoc_clk), .rst_int_n(rst_int_n),
    .cmd_valid(cmd_valid & sel), .cmd_ready(rdy_b), .cmd_read(cmd_read),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b), .busy(busy_b),
    .phy_mdio_i(phy_mdio_i), .phy_mdio_o(o_b), .phy_mdio_oe(oe_b), .phy_mdc(mdc_b)
  );

  assign o_ready = sel ? rdy_b  : rdy_a;
  assign o_rv    = sel ? rv_b   : rv_a;
  assign o_err   = sel ? err_b  : err_a;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_o     = sel ? o_b    : o_a;
  assign o_oe    = sel ? oe_b   : oe_a;
  assign o_mdc   = sel ? mdc_b  : mdc_a;
  assign o_rdata = sel ? rd_b   : rd_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One command, checked cycle by cycle from accept to cmd_ready returning.
  // hold keeps cmd_valid high after accept; abort_k>0 pulses reset at that cycle.
  task automatic run_txn(input logic rd, input logic [4:0] phy, input logic [4:0] regad,
                         input logic [15:0] wd, input logic [15:0] rword,
                         input logic nophy, input logic hold, input int abort_k);
    bit          eb[$];
    bit          rb[$];
    logic [31:0] hdr, rsp;
    logic [15:0] exp_rd;
    logic        exp_err, oe_e;
    int          pre, n, c2, b, p, lim;
    pre = sel ? 0 : 32;
    n   = pre + 32;
    c2  = 2 * CDIV;
    hdr = {2'b01, rd ? 2'b10 : 2'b01, phy, regad, rd ? 2'b11 : 2'b10, rd ? 16'hFFFF : wd};
    rsp = {14'h3FFF, 1'b1, nophy, nophy ? 16'hFFFF : rword};
    for (int i = 0; i < pre; i++) begin eb.push_back(1'b1); rb.push_back(1'b1); end
    for (int i = 31; i >= 0; i--) begin eb.push_back(hdr[i]); rb.push_back(rsp[i]); end
    exp_rd  = !rd ? 16'h0000 : (nophy ? 16'hFFFF : rword);
    exp_err = rd && nophy;

    cmd_read = rd; cmd_phy_addr = phy; cmd_reg_addr = regad; cmd_wdata = wd;
    cmd_valid = 1'b1;
    lim = 0;
    while (!o_ready && lim < 600) begin @(negedge msoc_clk); lim++; end
    chk("accept_ready", 32'(o_ready), 32'd1);
    if (!o_ready) begin cmd_valid = 1'b0; return; end
    @(negedge msoc_clk);
    cmd_valid = hold;
    cmd_read = 1'($urandom); cmd_phy_addr = 5'($urandom); cmd_reg_addr = 5'($urandom);
    cmd_wdata = 16'($urandom);

    for (int k = 1; k <= n * c2 + 2; k++) begin
      if (k <= n * c2) begin
        b = (k - 1) / c2;
        p = (k - 1) % c2;
        chk("mdc", 32'(o_mdc), 32'(p >= CDIV));
        chk("busy_ready_valid", 32'({o_busy, o_ready, o_rv}), 32'(3'b100));
        chk("rsp_hold", 32'({o_err, o_rdata}), 32'({last_err, last_rd}));
        oe_e = !rd || (b < pre + 14);
        chk("mdio_oe", 32'(o_oe), 32'(oe_e));
        if (oe_e) chk("mdio_o", 32'(o_o), 32'(eb[b]));
        // Valid only around the rising edge; the rest of the bit carries the complement.
        phy_mdio_i = nophy ? 1'b1 : ((p == CDIV - 1 || p == CDIV) ? rb[b] : ~rb[b]);
        if (k == abort_k) begin
          #1 rst_int_n = 1'b0;
          #1;
          chk("abort_outputs", 32'({o_mdc, o_oe, o_o, o_ready, o_busy, o_rv}), 32'(6'b001100));
          last_rd = '0; last_err = 1'b0;
          @(negedge msoc_clk);
          rst_int_n = 1'b1;
          cmd_valid = 1'b0;
          for (int j = 0; j < n * c2; j++) begin
            @(negedge msoc_clk);
            chk("abort_no_rsp", 32'({o_rv, o_ready, o_mdc, o_oe}), 32'(4'b0100));
          end
          phy_mdio_i = 1'b1;
          return;
        end
      end else if (k == n * c2 + 1) begin
        chk("rsp_cycle", 32'({o_rv, o_busy, o_ready, o_mdc, o_oe, o_o}), 32'(6'b110001));
        chk("rsp_rdata", 32'(o_rdata), 32'(exp_rd));
        chk("rsp_err", 32'(o_err), 32'(exp_err));
        last_rd = exp_rd; last_err = exp_err;
      end else begin
        chk("ready_after", 32'({o_rv, o_busy, o_ready, o_mdc, o_oe, o_o}), 32'(6'b001001));
        chk("rsp_hold_idle", 32'({o_err, o_rdata}), 32'({last_err, last_rd}));
      end
      if (k < n * c2 + 2) @(negedge msoc_clk);
    end
    phy_mdio_i = 1'b1;
  endtask

  initial begin
    logic r, np;
    #2 rst_int_n = 1'b0;
    repeat (2) @(negedge msoc_clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("reset_ctrl", 32'({o_ready, o_busy, o_rv, o_err, o_mdc, o_o, o_oe}), 32'(7'b1000010));
      chk("reset_rdata", 32'(o_rdata), 32'd0);
    end
    sel = 1'b0;
    @(negedge msoc_clk);
    rst_int_n = 1'b1;
    @(negedge msoc_clk);

    run_txn(1'b0, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b0, 1'b0, 0);
    run_txn(1'b1, 5'd1, 5'd2, 16'h0000, 16'h796D, 1'b0, 1'b0, 0);
    run_txn(1'b1, 5'd7, 5'd1, 16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    // Queued pair: cmd_valid stays high through the first frame.
    run_txn(1'b0, 5'd3, 5'd4, 16'(($urandom)), 16'h0000, 1'b0, 1'b1, 0);
    run_txn(1'b1, 5'd3, 5'd5, 16'h0000, 16'($urandom), 1'b0, 1'b0, 0);
    run_txn(1'b0, 5'd5, 5'd9, 16'hA5A5, 16'h0000, 1'b0, 1'b0, (32 + 6) * 2 * CDIV + 2);
    run_txn(1'b0, 5'd2, 5'd3, 16'h1234, 16'h0000, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      r  = 1'($urandom);
      np = r && ($urandom_range(0, 3) == 0);
      run_txn(r, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), np, 1'($urandom), 0);
    end
    // Flush any held cmd_valid by one plain frame before switching builds.
    run_txn(1'b0, 5'd0, 5'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);

    sel = 1'b1;
    last_rd = '0; last_err = 1'b0;
    @(negedge msoc_clk);
    run_txn(1'b0, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b0, 1'b0, 0);
    run_txn(1'b1, 5'd9, 5'd17, 16'h0000, 16'h8001, 1'b0, 1'b0, 0);
    run_txn(1'b1, 5'd4, 5'd30, 16'h0000, 16'h0000, 1'b1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/eth_mdio_master.md
Name: eth_mdio_master

Overview:
- Hardware Clause-22 MDIO management controller for the RGMII PHY. It replaces software bit-banging of phy_mdc, phy_mdio_o and phy_mdio_oe.
- It accepts one read or write command at a time through a valid/ready handshake. It serialises the 64-bit management frame and returns read data and a no-PHY error flag.
- It sits in the msoc_clk domain beside the framing register block, which drives its command port and reads its response.

Parameters:
- CLK_DIV, 50, msoc_clk cycles per MDC half-period; legal range 2..255. MDC frequency = msoc_clk / (2*CLK_DIV).
- PREAMBLE_BITS, 32, number of leading '1' preamble bits; legal range 0..32.

Ports:
- msoc_clk  in  1  block clock
- rst_int_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  block is idle and can accept a command
- cmd_read  in  1  1 = read (OP=10), 0 = write (OP=01)
- cmd_phy_addr  in  5  PHYAD
- cmd_reg_addr  in  5  REGAD
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse at frame completion
- rsp_rdata  out  16  read data; 0 after a write
- rsp_err  out  1  read turnaround bit sampled as 1 (no PHY responded)
- busy  out  1  frame in progress
- phy_mdio_i  in  1  MDIO pad input
- phy_mdio_o  out  1  MDIO pad output
- phy_mdio_oe  out  1  MDIO pad output enable
- phy_mdc  out  1  management clock

Behaviour:
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, phy_mdc=0, phy_mdio_o=1, phy_mdio_oe=0, FSM=IDLE, prescaler=0.
- States:
  - IDLE -> SHIFT on cmd_valid&cmd_ready. Command fields are latched at this edge.
  - SHIFT -> DONE after the last bit's high phase ends.
  - DONE -> IDLE unconditionally after 1 cycle.
- cmd_ready = (state==IDLE). busy = (state!=IDLE).
- Frame bit order, indices relative to the end of the preamble:
  - P = preamble, PREAMBLE_BITS ones
  - ST = 01 at bits 0-1
  - OP at bits 2-3
  - PHYAD at bits 4-8, MSB first
  - REGAD at bits 9-13, MSB first
  - TA at bits 14-15
  - DATA at bits 16-31, MSB first
  - Total frame length N = PREAMBLE_BITS+32.
- Bit timing: each bit is CLK_DIV cycles with MDC low, then CLK_DIV cycles with MDC high.
  - phy_mdio_o/oe change only at the start of the low phase.
  - The first low phase starts the cycle after accept.
- Drive rules:
  - Write: oe=1 for all bits; TA driven as 10.
  - Read: oe=1 through REGAD; oe=0 for TA and DATA.
  - After the frame ends: oe=0, o=1.
- Sampling: phy_mdio_i is sampled in the cycle MDC transitions low->high.
  - Read TA bit 15: a sampled 1 sets rsp_err.
  - DATA bits are shifted into rsp_rdata, MSB first.
  - Writes: rsp_rdata=0, rsp_err=0.
- Latency: accept at cycle 0 -> rsp_valid high at cycle 1+2*CLK_DIV*N for exactly one cycle. cmd_ready rises the cycle after.
  - Example: CLK_DIV=2, N=64 gives rsp_valid at cycle 257.
- rsp_rdata/rsp_err update in the rsp_valid cycle and hold until the next rsp_valid.
- Boundary conditions:
  - cmd_valid while busy or in DONE: ignored, not accepted. Command inputs may change freely after accept.
  - Back-to-back commands: the earliest next accept is the cycle after rsp_valid. MDC rests low for at least 1 cycle between frames.
  - Bit and prescaler counters are sized so that N=64 and CLK_DIV=255 do not wrap.
  - PREAMBLE_BITS=0: the frame starts directly at ST.
  - Reset asserted mid-frame: all outputs go to their reset values immediately. No rsp_valid is produced for the aborted frame.

Decomposition:
- Shared package eth_mdio_pkg holds:
  - constants ST_CODE=2'b01, OP_WRITE=2'b01, OP_READ=2'b10, TA_WRITE=2'b10
  - frame field index constants
  - the state enum mdio_state_t {IDLE, SHIFT, DONE}
- One sub-module, eth_mdio_clkgen: the prescaler. It outputs the MDC level plus one-cycle rise_stb/fall_stb strobes, and is held at 0/low while the FSM is not in SHIFT.

Test Plan:
Configuration: CLK_DIV=2, PREAMBLE_BITS=32. A PHY BFM samples MDIO on MDC rising edges.
- Write PHY 1, reg 0, data 0x1140 -> BFM captures 32 ones, then 01 01 00001 00000 10 0001000101000000. rsp_valid at cycle 257, rsp_rdata=0, rsp_err=0.
- Read PHY 1, reg 2; BFM drives TA=0, data 0x796D -> oe=0 from TA onward. rsp_rdata=0x796D, rsp_err=0.
- Read PHY 7 with no BFM response (phy_mdio_i pulled to 1) -> rsp_err=1, rsp_rdata=0xFFFF.
- cmd_valid held high with two queued commands -> second accept occurs the cycle after the first rsp_valid. cmd_ready stays low in between. The MDC period measured as 4 cycles throughout.
- rst_int_n pulsed low during PHYAD bits -> phy_mdc=0, oe=0, o=1, cmd_ready=1 in the same cycle. No rsp_valid. A following write completes correctly.
- PREAMBLE_BITS=0 build, write -> first MDC-high samples ST=0,1. rsp_valid at cycle 129.
